// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// Optional statistics are enabled with the FIFO_ARB_STATS_EN macro.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

  // Saturating increment for the per-requester beat counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    logic [STAT_W-1:0] res;
    if (v == {STAT_W{1'b1}}) begin
      res = v;
    end else begin
      res = v + {{(STAT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first valid index after
// i_last, wrapping from N-1 back to 0 (i_last itself is checked last).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_last,
  output logic          o_found,
  output logic [IW-1:0] o_index
);

  // Scan from farthest to nearest so the nearest valid index wins.
  always_comb begin
    int w_idx;
    o_found = 1'b0;
    o_index = '0;
    w_idx   = 0;
    for (int k = N; k >= 1; k--) begin
      w_idx = (int'(i_last) + k) % N;
      if (i_valid[w_idx]) begin
        o_found = 1'b1;
        o_index = IW'(w_idx);
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst round-robin arbiter funnelling N_REQ requesters into one sync FIFO.
// Optional feature macro: FIFO_ARB_STATS_EN adds stat_clr/stat_cnt with
// per-requester saturating beat counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       fifo_wr,
  output logic [WIDTH-1:0]           fifo_data,
  input  logic                       fifo_full,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [N_REQ*STAT_W-1:0]    stat_cnt
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    r_state,      w_state_nxt;
  logic [IW-1:0] r_grant_id,   w_grant_nxt;
  logic [IW-1:0] r_last_grant, w_last_nxt;
  logic [CW-1:0] r_burst_cnt,  w_cnt_nxt;

  logic          w_found;
  logic [IW-1:0] w_pick;
  logic          w_valid_g;
  logic          w_beat;
  logic [CW-1:0] w_cnt_inc;
  logic [N_REQ-1:0] w_req_ready;

  rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
    .i_valid (req_valid),
    .i_last  (r_last_grant),
    .o_found (w_found),
    .o_index (w_pick)
  );

  // Ready is combinational so a full FIFO or reset blocks the beat at once.
  always_comb begin
    w_req_ready = '0;
    if (r_state == BURST && !fifo_full) begin
      w_req_ready[r_grant_id] = 1'b1;
    end else begin
      w_req_ready = '0;
    end
  end

  assign w_valid_g = req_valid[r_grant_id];
  assign w_beat    = w_valid_g & w_req_ready[r_grant_id];
  assign w_cnt_inc = r_burst_cnt + CW'(1);

  assign req_ready = w_req_ready;
  assign fifo_wr   = w_beat;
  assign fifo_data = req_data[int'(r_grant_id)*WIDTH +: WIDTH];
  assign grant_id  = r_grant_id;
  assign busy      = (r_state == BURST);

  // Next-state logic: arbitrate in IDLE, count beats and stall in BURST.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_last_nxt  = r_last_grant;
    w_cnt_nxt   = r_burst_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BURST;
          w_grant_nxt = w_pick;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BURST: begin
        if (fifo_full) begin
          w_state_nxt = BURST;
        end else if (w_beat) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CW'(MAX_BURST)) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_grant_id;
          end else begin
            w_state_nxt = BURST;
          end
        end else if (!w_valid_g) begin
          // Requester ran dry: end the burst early and rotate priority.
          w_state_nxt = IDLE;
          w_last_nxt  = r_grant_id;
        end else begin
          w_state_nxt = BURST;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, grant, priority pointer and burst counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= IW'(N_REQ - 1);
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_burst_cnt  <= w_cnt_nxt;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [N_REQ-1:0][STAT_W-1:0] r_stat_cnt;

  // Per-requester saturating beat counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_cnt <= '0;
    end else if (stat_clr) begin
      r_stat_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_beat && (r_grant_id == IW'(i))) begin
          r_stat_cnt[i] <= sat_inc(r_stat_cnt[i]);
        end else begin
          r_stat_cnt[i] <= r_stat_cnt[i];
        end
      end
    end
  end

  assign stat_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (N_REQ=4, WIDTH=32,
// MAX_BURST=4). Statistics section is built when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         fifo_wr;
  logic [31:0]  fifo_data;
  logic         fifo_full;
  logic [1:0]   grant_id;
  logic         busy;
`ifdef FIFO_ARB_STATS_EN
  logic         stat_clr;
  logic [63:0]  stat_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  fifo_wr_arbiter #(.N_REQ(4), .WIDTH(32), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .fifo_full (fifo_full),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [31:0] exp_g;
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_data  = 128'd0;
    fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hA0 + 32'(i);

    // Reset state
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr", {31'd0, fifo_wr}, 32'd0);
    check("rst_ready", {28'd0, req_ready}, 32'd0);
    check("rst_grant", {30'd0, grant_id}, 32'd0);
    rst_n = 1'b1;
    tick();

    // All requesters valid: bursts of 4 in order 0,1,2,3,0 with one idle cycle
    req_valid = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      exp_g = 32'(b % 4);
      settle();
      check("rr_idle_busy", {31'd0, busy}, 32'd0);
      check("rr_idle_wr", {31'd0, fifo_wr}, 32'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
        check("rr_busy", {31'd0, busy}, 32'd1);
        check("rr_grant", {30'd0, grant_id}, exp_g);
        check("rr_wr", {31'd0, fifo_wr}, 32'd1);
        check("rr_data", fifo_data, 32'hA0 + exp_g);
        check("rr_ready", {28'd0, req_ready}, 32'd1 << exp_g);
        tick();
      end
    end

    // Only requester 2 valid: two words then drop -> early end, next search from 3
    req_valid = 4'b0100;
    req_data[64 +: 32] = 32'h1111_0000;
    settle();
    check("r2_idle", {31'd0, busy}, 32'd0);
    tick();
    check("r2_grant", {30'd0, grant_id}, 32'd2);
    check("r2_wr0", {31'd0, fifo_wr}, 32'd1);
    check("r2_data0", fifo_data, 32'h1111_0000);
    tick();
    req_data[64 +: 32] = 32'h1111_0001;
    settle();
    check("r2_wr1", {31'd0, fifo_wr}, 32'd1);
    check("r2_data1", fifo_data, 32'h1111_0001);
    tick();
    req_valid = 4'b0000;
    settle();
    check("r2_drop_busy", {31'd0, busy}, 32'd1);
    check("r2_drop_wr", {31'd0, fifo_wr}, 32'd0);
    tick();
    req_valid = 4'b1001;
    settle();
    check("r2_end_busy", {31'd0, busy}, 32'd0);
    tick();
    check("next_from3", {30'd0, grant_id}, 32'd3);
    check("next_wr", {31'd0, fifo_wr}, 32'd1);
    tick();
    req_valid = 4'b0000;
    settle();
    check("g3_drop_wr", {31'd0, fifo_wr}, 32'd0);
    tick();

    // Stall: fifo_full for 3 cycles mid-burst on requester 1
    req_valid = 4'b0010;
    req_data[32 +: 32] = 32'hD0;
    settle();
    check("st_idle", {31'd0, busy}, 32'd0);
    tick();
    check("st_grant", {30'd0, grant_id}, 32'd1);
    check("st_d0", fifo_data, 32'hD0);
    check("st_wr0", {31'd0, fifo_wr}, 32'd1);
    tick();
    req_data[32 +: 32] = 32'hD1;
    settle();
    check("st_d1", fifo_data, 32'hD1);
    check("st_wr1", {31'd0, fifo_wr}, 32'd1);
    tick();
    req_data[32 +: 32] = 32'hD2;
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("st_full_wr", {31'd0, fifo_wr}, 32'd0);
      check("st_full_rdy", {28'd0, req_ready}, 32'd0);
      check("st_full_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    fifo_full = 1'b0;
    settle();
    check("st_d2", fifo_data, 32'hD2);
    check("st_wr2", {31'd0, fifo_wr}, 32'd1);
    tick();
    req_data[32 +: 32] = 32'hD3;
    settle();
    check("st_d3", fifo_data, 32'hD3);
    check("st_wr3", {31'd0, fifo_wr}, 32'd1);
    tick();
    req_valid = 4'b0000;
    settle();
    check("st_end_busy", {31'd0, busy}, 32'd0);
    tick();

    // Reset pulse during a beat: no write, then requester 0 wins first
    req_valid = 4'b1111;
    settle();
    tick();
    check("rp_grant", {30'd0, grant_id}, 32'd2);
    check("rp_wr", {31'd0, fifo_wr}, 32'd1);
    rst_n = 1'b0;
    settle();
    check("rp_wr_rst", {31'd0, fifo_wr}, 32'd0);
    check("rp_rdy_rst", {28'd0, req_ready}, 32'd0);
    check("rp_busy_rst", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    settle();
    check("rp_idle", {31'd0, busy}, 32'd0);
    tick();
    check("rp_first_grant", {30'd0, grant_id}, 32'd0);
    check("rp_first_busy", {31'd0, busy}, 32'd1);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();

`ifdef FIFO_ARB_STATS_EN
    // Saturation of requester 1 counter, then synchronous clear
    begin
      int beats;
      int cyc;
      beats = 0;
      cyc   = 0;
      check("stat1_zero", {16'd0, stat_cnt[31:16]}, 32'd0);
      req_valid = 4'b0010;
      while (beats < 70000 && cyc < 95000) begin
        settle();
        if (fifo_wr) beats++;
        tick();
        cyc++;
      end
      req_valid = 4'b0000;
      check("stat_beats", 32'(beats), 32'd70000);
      tick(); tick();
      check("stat1_sat", {16'd0, stat_cnt[31:16]}, 32'h0000_FFFF);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      check("stat1_clr", {16'd0, stat_cnt[31:16]}, 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
